gate_preact_accum: RTL and testbench

//  Upstream neighbour of the sigmoid activation LUT in an LSTM gate datapath.
//  - Accepts a stream of signed Q4.12 (weight, input) pairs and multiply-accumulates them.
//  - Adds a Q4.12 bias, then rounds and saturates the result back to Q4.12.
//  - Presents one pre-activation per VEC_LEN-beat vector on a valid/ready port that drives the sigmoid's 16-bit x input.
//  - Saturation is mandatory: a wrapped value would flip sign and select the wrong sigmoid tail.

---
 rtl/lstm_fx_pkg.sv | 18 +
 rtl/fx_round_sat.sv | 40 ++++
 rtl/gate_preact_accum.sv | 141 ++++++++++++++
 tb/tb_gate_preact_accum.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lstm_fx_pkg.sv
// Shared Q4.12 fixed-point constants and the pre-activation accumulator FSM encoding.
package lstm_fx_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;

  localparam logic [DATA_WIDTH-1:0] Q412_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] Q412_MIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    ROUND,
    OUT
  } state_e;

endpackage

// File: rtl/fx_round_sat.sv
// Narrows a wide signed fixed-point accumulator to Q4.12: round-half-up, arithmetic shift, clamp.
module fx_round_sat
  import lstm_fx_pkg::*;
#(
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT_BITS = 12
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);

  localparam logic signed [ACC_WIDTH-1:0] HALF =
    {{(ACC_WIDTH-SHIFT_BITS){1'b0}}, 1'b1, {(SHIFT_BITS-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] w_rnd;
  logic signed [ACC_WIDTH-1:0] w_shr;

  // Adding half an LSB before the arithmetic shift gives ties toward +inf.
  assign w_rnd = $signed(i_acc) + HALF;
  assign w_shr = w_rnd >>> SHIFT_BITS;

  always_comb begin
    o_sat  = 1'b0;
    o_data = w_shr[OUT_WIDTH-1:0];
    if (w_shr > SAT_MAX) begin
      o_sat  = 1'b1;
      o_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_shr < SAT_MIN) begin
      o_sat  = 1'b1;
      o_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/gate_preact_accum.sv
// LSTM gate pre-activation: MAC over VEC_LEN (w,x) beats plus bias, rounded and saturated to Q4.12.
module gate_preact_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int VEC_LEN    = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);
  import lstm_fx_pkg::*;

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN);

  state_e                     r_state;
  logic [CNT_W-1:0]           r_count;
  logic signed [PROD_W-1:0]   r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [DATA_WIDTH-1:0]      r_out_data;
  logic                       r_out_sat;

  logic signed [PROD_W-1:0]    w_w_ext;
  logic signed [PROD_W-1:0]    w_x_ext;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        w_beat;
  logic [DATA_WIDTH-1:0]       w_rs_data;
  logic                        w_rs_sat;

  // Operands widened first so the product is exact in PROD_W bits.
  assign w_w_ext    = {{DATA_WIDTH{in_w[DATA_WIDTH-1]}}, in_w};
  assign w_x_ext    = {{DATA_WIDTH{in_x[DATA_WIDTH-1]}}, in_x};
  assign w_prod     = w_w_ext * w_x_ext;
  assign w_prod_ext = {{(ACC_WIDTH-PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){in_bias[DATA_WIDTH-1]}},
                       in_bias, {FRAC_BITS{1'b0}}};
  assign w_cnt_nxt  = r_count + CNT_W'(1);
  assign w_beat     = in_valid && r_in_ready;

  fx_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .SHIFT_BITS(FRAC_BITS)
  ) u_round_sat (
    .i_acc (r_acc),
    .o_data(w_rs_data),
    .o_sat (w_rs_sat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (w_beat) begin
            r_acc   <= w_bias_ext;
            r_prod  <= w_prod;
            r_count <= CNT_W'(1);
            if (CNT_W'(1) == CNT_LAST) begin
              r_in_ready <= 1'b0;
              r_state    <= DRAIN;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc   <= r_acc + w_prod_ext;
            r_prod  <= w_prod;
            r_count <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_LAST) begin
              r_in_ready <= 1'b0;
              r_state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_acc   <= r_acc + w_prod_ext;
          r_state <= ROUND;
        end
        ROUND: begin
          r_out_data  <= w_rs_data;
          r_out_sat   <= w_rs_sat;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_gate_preact_accum.sv
// Directed bench for gate_preact_accum with VEC_LEN=4 and hand-computed Q4.12 results.
module tb_gate_preact_accum;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_w;
  logic [15:0] in_x;
  logic [15:0] in_bias;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  gate_preact_accum #(
    .DATA_WIDTH(16),
    .FRAC_BITS (12),
    .VEC_LEN   (4),
    .ACC_WIDTH (40)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_w     (in_w),
    .in_x     (in_x),
    .in_bias  (in_bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the first n beats; a beat is taken on the posedge following a negedge where in_ready=1.
  task automatic beats(input string tag, input logic [15:0] b, input logic [3:0][15:0] w,
                       input logic [3:0][15:0] x, input int n, input bit bub);
    bit got;
    for (int i = 0; i < n; i++) begin
      if (bub && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_w     = 16'h7FFF;
        in_x     = 16'h7FFF;
      end
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_w     = w[i];
        in_x     = x[i];
        in_bias  = b;
        if (in_ready) got = 1'b1;
      end
      if (!got) check({tag, "_accept"}, 32'(got), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bias  = 16'hAAAA;
  endtask

  // mode 0: normal handshake, mode 1: leave the result pending in OUT.
  task automatic run_vec(input string tag, input logic [15:0] b, input logic [3:0][15:0] w,
                         input logic [3:0][15:0] x, input logic [15:0] exp_d, input logic exp_s,
                         input bit bub, input int stall, input int mode);
    beats(tag, b, w, x, 4, bub);
    check({tag, "_lat0_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_lat0_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
    end
    if (mode == 0) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin : stim
    int seen;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_w      = '0;
    in_x      = '0;
    in_bias   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    #2 resetn = 1'b1;
    #1 check("rel_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_post", 32'(in_ready), 32'd1);

    run_vec("t1", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 0, 0, 0);
    run_vec("t2_zero", 16'hF000, {4{16'h1000}}, {4{16'h0400}}, 16'h0000, 1'b0, 0, 0, 0);
    run_vec("t2_pos", 16'h0000, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 1'b1, 0, 0, 0);
    run_vec("t2_neg", 16'h0000, {4{16'h8000}}, {4{16'h7FFF}}, 16'h8000, 1'b1, 0, 0, 0);
    run_vec("t3_a", 16'h0000, {16'h0, 16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'h0, 16'h0800},
            16'h0001, 1'b0, 0, 0, 0);
    run_vec("t3_b", 16'h0000, {16'h0, 16'h0, 16'h0001, 16'h0}, {16'h0, 16'h0, 16'hF800, 16'h0},
            16'h0000, 1'b0, 0, 0, 0);
    run_vec("t3_c", 16'h0000, {16'h0003, 16'h0, 16'h0, 16'h0}, {16'h0800, 16'h0, 16'h0, 16'h0},
            16'h0002, 1'b0, 0, 0, 0);
    run_vec("t4_bub", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 1, 5, 0);

    // Abort after two beats: the partial vector must never surface.
    beats("t5_part", 16'h0000, {4{16'h7FFF}}, {4{16'h7FFF}}, 2, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_flush_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t5_no_valid", 32'(seen), 32'd0);
    run_vec("t5_clean", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 0, 0, 0);

    run_vec("t5_out", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 0, 2, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_outflush_valid", 32'(out_valid), 32'd0);
    check("t5_outflush_ready", 32'(in_ready), 32'd1);

    run_vec("t6_out", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 0, 1, 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    #1 check("t6_rel_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t6_rel_post", 32'(in_ready), 32'd1);
    run_vec("t6_after", 16'h0000, {4{16'h1000}}, {4{16'h0800}}, 16'h2000, 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
